// File: rtl/lea_rkey_b_stream_if.sv
// lea_rkey_b_stream_if.sv - job request and round-key word stream bundle for lea_rkey_b_stream
// Signals:
//   start, dir, b_in : job request (requester -> expander)
//   busy, done       : job status (expander -> requester)
//   rk_valid, rk_ready, rk_data, rk_idx, rk_last : derived-word stream with valid/ready handshake
// Modports: master = requester/consumer side, slave = expander side.
interface lea_rkey_b_stream_if;
    logic        start;
    logic        dir;
    logic [31:0] b_in;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [31:0] rk_data;
    logic [4:0]  rk_idx;
    logic        rk_last;
    logic        done;

    modport master (
        output start, dir, b_in, rk_ready,
        input  busy, rk_valid, rk_data, rk_idx, rk_last, done
    );

    modport slave (
        input  start, dir, b_in, rk_ready,
        output busy, rk_valid, rk_data, rk_idx, rk_last, done
    );
endinterface

// File: rtl/lea_rkey_b_stream.sv
// lea_rkey_b_stream.sv - sequential key-word-B expander emitting 24 derived words over a valid/ready stream
// Ports:
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset, aborts any job in progress
//   rk  : lea_rkey_b_stream_if.slave (start/dir/b_in request, busy/done status, rk_* word stream)
// Each word is rk(i) = ROL_ROT_OUT(B + ROL_(i+1)(delta[i%4])), produced by one shared adder/rotator
// indexed by the registered word counter.
module lea_rkey_b_stream #(
    parameter int NWORDS  = 24,
    parameter int ROT_OUT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    lea_rkey_b_stream_if.slave     rk
);
    localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] b_reg, b_nxt;
    logic        dir_reg, dir_nxt;
    logic [4:0]  idx, idx_nxt;
    logic        done_reg, done_nxt;

    logic        valid;
    logic        is_last;
    logic        xfer;
    logic [31:0] delta;
    logic [5:0]  rot;
    logic [31:0] delta_rot;
    logic [31:0] sum;
    logic [31:0] word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            b_reg    <= '0;
            dir_reg  <= 1'b0;
            idx      <= '0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            b_reg    <= b_nxt;
            dir_reg  <= dir_nxt;
            idx      <= idx_nxt;
            done_reg <= done_nxt;
        end
    end

    assign valid   = (state == RUN);
    assign is_last = dir_reg ? (idx == 5'd0) : (idx == LAST_IDX);
    assign xfer    = valid & rk.rk_ready;

    always_comb begin
        state_nxt = state;
        b_nxt     = b_reg;
        dir_nxt   = dir_reg;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rk.start) begin
                    b_nxt     = rk.b_in;
                    dir_nxt   = rk.dir;
                    idx_nxt   = rk.dir ? LAST_IDX : 5'd0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here: a running job cannot be retargeted.
                if (xfer) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = dir_reg ? idx - 5'd1 : idx + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared word datapath, driven only from registered b_reg/idx so the word is stable across stalls.
    always_comb begin
        case (idx[1:0])
            2'd0:    delta = 32'hC3EFE9DB;
            2'd1:    delta = 32'h44626B02;
            2'd2:    delta = 32'h79E27C8A;
            default: delta = 32'h78DF30EC;
        endcase
    end

    // Rotate amount idx+1 stays in 1..24, so both shift terms are well defined.
    assign rot       = {1'b0, idx} + 6'd1;
    assign delta_rot = (delta << rot) | (delta >> (6'd32 - rot));
    assign sum       = b_reg + delta_rot;
    assign word      = {sum[31-ROT_OUT:0], sum[31:32-ROT_OUT]};

    assign rk.busy     = valid;
    assign rk.rk_valid = valid;
    assign rk.rk_last  = valid & is_last;
    assign rk.rk_idx   = valid ? idx : 5'd0;
    assign rk.rk_data  = valid ? word : 32'd0;
    assign rk.done     = done_reg;
endmodule

// File: tb/tb_lea_rkey_b_stream.sv
// tb/tb_lea_rkey_b_stream.sv - self-checking bench for lea_rkey_b_stream
module tb_lea_rkey_b_stream;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    lea_rkey_b_stream_if bus ();

    lea_rkey_b_stream dut (
        .clk (clk),
        .rst (rst),
        .rk  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        logic [31:0] b;
        int          rpct;
        bit          mid;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } job_t;

    job_t jobs[10];

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] b, input int i);
        logic [31:0] deltas[4];
        deltas[0] = 32'hC3EFE9DB;
        deltas[1] = 32'h44626B02;
        deltas[2] = 32'h79E27C8A;
        deltas[3] = 32'h78DF30EC;
        return rol(b + rol(deltas[i % 4], i + 1), 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm, input logic exp_done);
        chk({nm, "_valid"}, {31'd0, bus.rk_valid}, 32'd0);
        chk({nm, "_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({nm, "_data"},  bus.rk_data, 32'd0);
        chk({nm, "_idx"},   {27'd0, bus.rk_idx}, 32'd0);
        chk({nm, "_last"},  {31'd0, bus.rk_last}, 32'd0);
        chk({nm, "_done"},  {31'd0, bus.done}, {31'd0, exp_done});
    endtask

    // Entered and left on a negedge; returns in the done cycle (or after abort_at transfers).
    task automatic run_job(input job_t jb, input int abort_at);
        int k;
        int cyc;
        int ei;
        bus.start    = 1'b1;
        bus.dir      = jb.dir;
        bus.b_in     = jb.b;
        bus.rk_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 24 && cyc < 1000) begin
            if (abort_at >= 0 && k == abort_at) return;
            ei = jb.dir ? 23 - k : k;
            chk("run_valid", {31'd0, bus.rk_valid}, 32'd1);
            chk("run_busy",  {31'd0, bus.busy}, 32'd1);
            chk("run_idx",   {27'd0, bus.rk_idx}, ei);
            chk("run_data",  bus.rk_data, golden(jb.b, ei));
            chk("run_last",  {31'd0, bus.rk_last}, {31'd0, k == 23});
            chk("run_done",  {31'd0, bus.done}, 32'd0);
            if (k == 0)  chk("first_word", bus.rk_data, jb.exp_first);
            if (k == 23) chk("last_word",  bus.rk_data, jb.exp_last);
            bus.rk_ready = ($urandom_range(0, 99) < jb.rpct);
            if (jb.mid) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.b_in  = $urandom;
                bus.dir   = $urandom_range(0, 1);
            end
            if (bus.rk_ready) k++;
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.rk_ready = 1'b0;
        chk("transfer_count", k, 24);
        chk_idle("done_cycle", 1'b1);
    endtask

    initial begin
        job_t ab;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dir      = 1'b0;
        bus.b_in     = 32'd0;
        bus.rk_ready = 1'b0;

        jobs[0] = '{1'b0, 32'h0, 100, 1'b0, 32'h3EFE9DBC, 32'h63C6F987};
        jobs[1] = '{1'b1, 32'h0, 100, 1'b0, 32'h63C6F987, 32'h3EFE9DBC};
        jobs[2] = '{1'b0, 32'hFFFFFFFF, 100, 1'b0, golden(32'hFFFFFFFF, 0), golden(32'hFFFFFFFF, 23)};
        jobs[3] = '{1'b1, 32'hFFFFFFFF, 60, 1'b0, golden(32'hFFFFFFFF, 23), golden(32'hFFFFFFFF, 0)};
        for (int j = 4; j < 10; j++) begin
            jobs[j].dir       = $urandom_range(0, 1);
            jobs[j].b         = $urandom;
            jobs[j].rpct      = $urandom_range(30, 90);
            jobs[j].mid       = (j >= 7);
            jobs[j].exp_first = golden(jobs[j].b, jobs[j].dir ? 23 : 0);
            jobs[j].exp_last  = golden(jobs[j].b, jobs[j].dir ? 0 : 23);
        end

        repeat (3) @(negedge clk);
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset", 1'b0);

        // Jobs chain back-to-back (start in the done cycle) except where an idle gap is inserted.
        for (int j = 0; j < 10; j++) begin
            run_job(jobs[j], -1);
            if (j % 2 == 1) begin
                @(negedge clk);
                chk_idle("gap", 1'b0);
            end
        end

        // Abort after 10 transfers: no done pulse, then a fresh reverse job restarts at 23.
        ab = '{1'b0, $urandom, 100, 1'b0, 32'h0, 32'h0};
        ab.exp_first = golden(ab.b, 0);
        run_job(ab, 10);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("abort_no_done", 1'b0);
        ab = '{1'b1, $urandom, 70, 1'b0, 32'h0, 32'h0};
        ab.exp_first = golden(ab.b, 23);
        ab.exp_last  = golden(ab.b, 0);
        run_job(ab, -1);

        // rst wins over start in the same cycle.
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk_idle("rst_vs_start", 1'b0);
        @(negedge clk);
        chk_idle("rst_vs_start_hold", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
